// File: rtl/glyph_fetch_ctrl.sv
// Text-mode glyph fetcher: walks COLS cells of the text buffer and serialises one 6-px glyph row per cell.
// Optional cursor inversion when GLYPH_CURSOR_EN is defined.
module glyph_fetch_ctrl #(
    parameter int COLS = 10,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          line_start,
    input  logic [2:0]    glyph_row,
    input  logic          pixel_en,
    output logic [CW-1:0] text_addr,
    input  logic [6:0]    text_char,
    output logic [6:0]    rom_addr,
    input  logic [34:0]   rom_data,
`ifdef GLYPH_CURSOR_EN
    input  logic          cursor_on,
    input  logic [CW-1:0] cursor_col,
`endif
    output logic          pixel,
    output logic          pixel_valid,
    output logic          busy
);
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_ACTIVE} state_t;

    localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
    localparam logic [1:0]    FETCH_DONE = 2'd3;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_text_addr;
    logic [CW-1:0] r_cell;
    logic [CW-1:0] w_cell_nxt;
    logic [6:0]    r_rom_addr;
    logic [2:0]    r_row;
    logic [2:0]    r_col;
    logic [1:0]    r_fetch;
    logic [5:0]    r_shift;
    logic [4:0]    r_pf_buf;
    logic [4:0]    w_row_bits;
    logic          w_inv_first;
    logic          w_inv_next;
    logic          w_last_px;

    assign text_addr  = r_text_addr;
    assign rom_addr   = r_rom_addr;
    assign w_cell_nxt = r_cell + CW'(1);
    assign w_last_px  = (r_state == S_ACTIVE) && pixel_en && (r_col == 3'd5) && (r_cell == LAST_COL);

`ifdef GLYPH_CURSOR_EN
    logic          r_cur_on;
    logic [CW-1:0] r_cur_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_on  <= 1'b0;
            r_cur_col <= '0;
        end else if (line_start) begin
            r_cur_on  <= cursor_on;
            r_cur_col <= cursor_col;
        end
    end

    assign w_inv_first = r_cur_on && (r_cur_col == '0);
    assign w_inv_next  = r_cur_on && (r_cur_col == w_cell_nxt);
`else
    assign w_inv_first = 1'b0;
    assign w_inv_next  = 1'b0;
`endif

    // Row 7 is the inter-line gap: no ROM bits back it, so it stays blank.
    always_comb begin
        w_row_bits = 5'd0;
        for (int r = 0; r < 7; r++) begin
            if (r_row == 3'(r)) begin
                w_row_bits = rom_data[5*r +: 5];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (line_start) begin
            w_state_nxt = S_PRIME;
        end else begin
            case (r_state)
                S_PRIME:  if (r_fetch == 2'd2) w_state_nxt = S_ACTIVE;
                S_ACTIVE: if (w_last_px)       w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pixel       = 1'b0;
        pixel_valid = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_PRIME: busy = 1'b1;
            S_ACTIVE: begin
                busy        = 1'b1;
                pixel_valid = 1'b1;
                pixel       = r_shift[5];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_text_addr <= '0;
            r_rom_addr  <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_cell      <= '0;
            r_fetch     <= '0;
            r_shift     <= '0;
            r_pf_buf    <= '0;
        end else if (line_start) begin
            r_text_addr <= '0;
            r_row       <= glyph_row;
            r_col       <= '0;
            r_cell      <= '0;
            r_fetch     <= '0;
            r_shift     <= '0;
        end else if (r_state != S_IDLE) begin
            // Fetch pipeline: address out, char into rom_addr, row captured.
            case (r_fetch)
                2'd0: r_fetch <= 2'd1;
                2'd1: begin
                    r_rom_addr <= text_char;
                    r_fetch    <= 2'd2;
                end
                2'd2: begin
                    r_fetch <= FETCH_DONE;
                    if (r_state == S_PRIME) begin
                        r_shift     <= {w_row_bits, 1'b0} ^ {6{w_inv_first}};
                        r_col       <= '0;
                        r_cell      <= '0;
                        r_text_addr <= r_text_addr + CW'(1);
                        r_fetch     <= 2'd0;
                    end else begin
                        r_pf_buf <= w_row_bits;
                    end
                end
                default: ;
            endcase

            if (r_state == S_ACTIVE && pixel_en) begin
                if (r_col != 3'd5) begin
                    r_shift <= {r_shift[4:0], 1'b0};
                    r_col   <= r_col + 3'd1;
                end else if (r_cell != LAST_COL) begin
                    r_shift <= {r_pf_buf, 1'b0} ^ {6{w_inv_next}};
                    r_col   <= '0;
                    r_cell  <= w_cell_nxt;
                    // text_addr already points at the cell just loaded; stop once it is the last one.
                    if (r_text_addr != LAST_COL) begin
                        r_text_addr <= r_text_addr + CW'(1);
                        r_fetch     <= 2'd0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_glyph_fetch_ctrl.sv
// Scoreboard bench for glyph_fetch_ctrl: expected pixels queued by stimulus, popped by a monitor on accepted pixels.
module tb_glyph_fetch_ctrl;
    localparam int COLS = 10;
    localparam int CW   = 4;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          line_start = 1'b0;
    logic [2:0]    glyph_row  = 3'd0;
    logic          pixel_en   = 1'b0;
    logic [CW-1:0] text_addr;
    logic [6:0]    text_char  = 7'd0;
    logic [6:0]    rom_addr;
    logic [34:0]   rom_data;
    logic          pixel;
    logic          pixel_valid;
    logic          busy;
`ifdef GLYPH_CURSOR_EN
    logic          cursor_on  = 1'b0;
    logic [CW-1:0] cursor_col = '0;
`endif

    logic [6:0] tmem [COLS];
    logic [6:0] pat  [COLS] = '{7'h53, 7'h0A, 7'h1F, 7'h41, 7'h16, 7'h28, 7'h79, 7'h04, 7'h31, 7'h6E};
    int         rom_mode  = 0;
    logic       cur_on_m  = 1'b0;
    int         cur_col_m = 0;

    logic          exp_q [$];
    int            addr_log [$];
    int            n_total  = 0;
    int            n_pass   = 0;
    int            n_pe     = 0;
    int            addr_bad = 0;
    logic          log_en   = 1'b0;
    logic [CW-1:0] last_addr = '0;
    logic          e;

    glyph_fetch_ctrl #(.COLS(COLS), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_start  (line_start),
        .glyph_row   (glyph_row),
        .pixel_en    (pixel_en),
        .text_addr   (text_addr),
        .text_char   (text_char),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
`ifdef GLYPH_CURSOR_EN
        .cursor_on   (cursor_on),
        .cursor_col  (cursor_col),
`endif
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Synchronous text buffer: data appears one clock after the address.
    always @(posedge clk) text_char <= (int'(text_addr) < COLS) ? tmem[text_addr] : 7'h00;

    function automatic logic [34:0] rom_model(input logic [6:0] code, input int mode);
        case (mode)
            0:       return (code < 7'd32) ? 35'h7FFFFFFFF : 35'h0;
            1:       return 35'h7FFFFFFFF;
            default: return {7{code[4:0]}};
        endcase
    endfunction

    assign rom_data = rom_model(rom_addr, rom_mode);

    function automatic logic exp_px(input int c, input int p, input int row);
        logic [34:0] rd;
        logic        b;
        rd = rom_model(tmem[c], rom_mode);
        b  = (p < 5 && row < 7) ? rd[5*row + 4 - p] : 1'b0;
        if (cur_on_m && c == cur_col_m) b = ~b;
        return b;
    endfunction

    function automatic void check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endfunction

    task automatic push_pixels(input int row, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_px(i / 6, i % 6, row));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int row);
        glyph_row  = 3'(row);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic run_to_idle(input int mode, input string tag);
        int k;
        k = 0;
        while (busy && k < 2000) begin
            pixel_en = (mode == 0) ? 1'b1 : (k % 3 == 2);
            tick();
            k++;
        end
        pixel_en = 1'b1;
        check({tag, "_done"}, int'(busy), 0);
        check({tag, "_valid_low"}, int'(pixel_valid), 0);
        check({tag, "_pixel_low"}, int'(pixel), 0);
        check({tag, "_drain"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && pixel_valid && pixel_en) begin
            if (exp_q.size() == 0) begin
                check("stray_pixel", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pixel", int'(pixel), int'(e));
            end
            n_pe++;
        end
        if (int'(text_addr) >= COLS) addr_bad++;
        if (log_en && text_addr != last_addr) addr_log.push_back(int'(text_addr));
        last_addr = text_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < COLS; i++) tmem[i] = 7'h05;

        // Reset state
        #2;
        check("rst_pixel", int'(pixel), 0);
        check("rst_valid", int'(pixel_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_text_addr", int'(text_addr), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_idle", int'(busy), 0);

        // Blank-code glyphs, row 0, full-rate pixels: 3 PRIME clocks then 10 x 111110
        rom_mode = 0;
        pixel_en = 1'b1;
        push_pixels(0, 60);
        pulse(0);
        check("prime0_valid", int'(pixel_valid), 0);
        check("prime0_busy", int'(busy), 1);
        check("prime0_addr", int'(text_addr), 0);
        tick();
        check("prime1_valid", int'(pixel_valid), 0);
        tick();
        check("prime2_valid", int'(pixel_valid), 0);
        tick();
        check("active_after3", int'(pixel_valid), 1);
        run_to_idle(0, "line_ones");
        check("idle_addr_hold", int'(text_addr), COLS - 1);

        // Row 7 is blank even with an all-ones ROM
        rom_mode = 1;
        push_pixels(7, 60);
        pulse(7);
        run_to_idle(0, "row7");

        // Slow pixel_en: one pulse every third clock
        rom_mode = 0;
        push_pixels(0, 60);
        n_pe = 0;
        addr_log.delete();
        log_en = 1'b1;
        pulse(0);
        run_to_idle(1, "slow");
        log_en = 1'b0;
        check("slow_pe_count", n_pe, 60);
        check("slow_addr_changes", addr_log.size(), COLS);
        for (int i = 0; i < addr_log.size() && i < COLS; i++) check("slow_addr_seq", addr_log[i], i);

        // Restart at pixel 20 with distinct glyphs per cell
        rom_mode = 2;
        for (int i = 0; i < COLS; i++) tmem[i] = pat[i];
        push_pixels(4, 20);
        pulse(4);
        repeat (22) tick();
        push_pixels(1, 60);
        pulse(1);
        check("abort_valid_low", int'(pixel_valid), 0);
        check("abort_busy", int'(busy), 1);
        check("abort_addr0", int'(text_addr), 0);
        tick();
        tick();
        check("abort_prime2", int'(pixel_valid), 0);
        tick();
        check("abort_reactive", int'(pixel_valid), 1);
        run_to_idle(0, "abort");

        // Reset asserted during cell 4
        push_pixels(2, 24);
        pulse(2);
        repeat (27) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_pixel", int'(pixel), 0);
        check("midrst_valid", int'(pixel_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_text_addr", int'(text_addr), 0);
        check("midrst_rom_addr", int'(rom_addr), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("midrst_wait_busy", int'(busy), 0);
        check("midrst_wait_addr", int'(text_addr), 0);
        check("midrst_drain", exp_q.size(), 0);

`ifdef GLYPH_CURSOR_EN
        // Cursor on cell 3 over blank glyphs
        rom_mode   = 1;
        cur_on_m   = 1'b1;
        cur_col_m  = 3;
        cursor_on  = 1'b1;
        cursor_col = 4'd3;
        push_pixels(7, 60);
        pulse(7);
        cursor_on  = 1'b0;
        run_to_idle(0, "cursor");
        cur_on_m   = 1'b0;
`endif

        check("addr_range", addr_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
